// File: rtl/pe_command_issuer.sv
// Host-side sequencer: queues commands and issues them to the PE one at a time.
// Abort-on-timeout in WAIT_DONE is compiled in with `define PE_COMMAND_ISSUER_TIMEOUT_EN.
module pe_command_issuer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [31:0]                   cmd_command,
    input  logic [31:0]                   cmd_argument_1,
    input  logic [31:0]                   cmd_argument_2,
    input  logic [31:0]                   cmd_argument_3,
    output logic                          pe_start,
    output logic [31:0]                   pe_command,
    output logic [31:0]                   pe_argument_1,
    output logic [31:0]                   pe_argument_2,
    output logic [31:0]                   pe_argument_3,
    input  logic                          pe_busy,
    input  logic                          pe_command_done,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [1:0]                    rsp_status,
    output logic [31:0]                   rsp_cycles,
    output logic [$clog2(FIFO_DEPTH):0]   pending_count,
    output logic                          idle,
    output logic [1:0]                    fsm_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_RESPOND   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [127:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       issue_q, issue_d;
    logic [31:0]        cyc_q, cyc_d;
    logic [31:0]        cyc_inc;
    logic [31:0]        rsp_cycles_q, rsp_cycles_d;
    logic [1:0]         rsp_status_q, rsp_status_d;
    logic               push;
    logic               pop;

`ifndef PE_COMMAND_ISSUER_TIMEOUT_EN
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    // Both host channels are valid/ready: a transfer occurs on a rising edge where
    // valid and ready are both high; the response holds valid and payload until then.
    assign cmd_ready = (cnt_q != CNT_W'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (cnt_q != '0) && !pe_busy;
    assign cyc_inc   = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_command, cmd_argument_1, cmd_argument_2, cmd_argument_3};
        end
    end

    always_comb begin
        state_d      = state_q;
        issue_d      = issue_q;
        cyc_d        = cyc_q;
        rsp_status_d = rsp_status_q;
        rsp_cycles_d = rsp_cycles_q;
        pe_start     = 1'b0;
        rsp_valid    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    issue_d = mem_q[rd_ptr_q];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pe_start = 1'b1;
                cyc_d    = 32'd1;
                state_d  = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // cyc_inc is the inclusive count from the start cycle to this one.
                cyc_d = cyc_inc;
                if (pe_command_done) begin
                    rsp_status_d = 2'b00;
                    rsp_cycles_d = cyc_inc;
                    state_d      = S_RESPOND;
                end
`ifdef PE_COMMAND_ISSUER_TIMEOUT_EN
                else if (cyc_inc == 32'(TIMEOUT_CYCLES)) begin
                    rsp_status_d = 2'b01;
                    rsp_cycles_d = 32'(TIMEOUT_CYCLES);
                    state_d      = S_RESPOND;
                end
`endif
            end
            S_RESPOND: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            issue_q      <= '0;
            cyc_q        <= '0;
            rsp_status_q <= '0;
            rsp_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            issue_q      <= issue_d;
            cyc_q        <= cyc_d;
            rsp_status_q <= rsp_status_d;
            rsp_cycles_q <= rsp_cycles_d;
        end
    end

    assign pe_command    = issue_q[127:96];
    assign pe_argument_1 = issue_q[95:64];
    assign pe_argument_2 = issue_q[63:32];
    assign pe_argument_3 = issue_q[31:0];
    assign rsp_status    = rsp_status_q;
    assign rsp_cycles    = rsp_cycles_q;
    assign pending_count = cnt_q;
    assign idle          = (state_q == S_IDLE) && (cnt_q == '0);
    assign fsm_state     = state_q;

endmodule
